// File: rtl/lemmings_dig_ctrl_if.sv
// Terrain/command inputs and animation outputs of one Lemming walker.
// Optional macro LEMMINGS_REVIVE_EN adds the revive command.
interface lemmings_dig_ctrl_if;
  logic bump_left;
  logic bump_right;
  logic ground;
  logic dig;
`ifdef LEMMINGS_REVIVE_EN
  logic revive;
`endif
  logic walk_left;
  logic walk_right;
  logic aaah;
  logic digging;

  modport master (
`ifdef LEMMINGS_REVIVE_EN
    output revive,
`endif
    output bump_left, bump_right, ground, dig,
    input  walk_left, walk_right, aaah, digging
  );

  modport slave (
`ifdef LEMMINGS_REVIVE_EN
    input  revive,
`endif
    input  bump_left, bump_right, ground, dig,
    output walk_left, walk_right, aaah, digging
  );
endinterface

// File: rtl/lemmings_dig_ctrl.sv
// Moore walk/fall/dig/splat controller for one Lemming with a saturating fall counter.
// Optional macro LEMMINGS_REVIVE_EN: revive command leaves SPLAT back to WALK_L.
module lemmings_dig_ctrl #(
  parameter int SPLAT_CYCLES = 20,
  parameter int CNT_W        = 5
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  lemmings_dig_ctrl_if.slave lem
);

  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    FALL_R = 3'd3,
    DIG_L  = 3'd4,
    DIG_R  = 3'd5,
    SPLAT  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(SPLAT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(SPLAT_CYCLES);

  state_t           cstate;
  state_t           nstate;
  logic [CNT_W-1:0] r_fall_cnt;
  logic [CNT_W-1:0] w_fall_cnt_next;
  logic             w_in_fall;
  logic             w_next_fall;
  logic             w_splat_due;

  assign w_in_fall   = (cstate == FALL_L) || (cstate == FALL_R);
  assign w_next_fall = (nstate == FALL_L) || (nstate == FALL_R);
  // r_fall_cnt holds completed fall cycles; the current cycle makes it +1 aaah cycles.
  assign w_splat_due = (r_fall_cnt >= CNT_LIMIT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cstate <= WALK_L;
    end else begin
      cstate <= nstate;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_fall_cnt <= '0;
    end else begin
      r_fall_cnt <= w_fall_cnt_next;
    end
  end

  // Counts only while staying in a fall; saturates so long falls can never wrap to survival.
  always_comb begin
    w_fall_cnt_next = '0;
    if (w_in_fall && w_next_fall) begin
      w_fall_cnt_next = (r_fall_cnt == CNT_SAT) ? CNT_SAT : r_fall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nstate = cstate;
    case (cstate)
      WALK_L: begin
        if (!lem.ground)        nstate = FALL_L;
        else if (lem.dig)       nstate = DIG_L;
        else if (lem.bump_left) nstate = WALK_R;
      end
      WALK_R: begin
        if (!lem.ground)         nstate = FALL_R;
        else if (lem.dig)        nstate = DIG_R;
        else if (lem.bump_right) nstate = WALK_L;
      end
      FALL_L: begin
        if (lem.ground) nstate = w_splat_due ? SPLAT : WALK_L;
      end
      FALL_R: begin
        if (lem.ground) nstate = w_splat_due ? SPLAT : WALK_R;
      end
      DIG_L: begin
        if (!lem.ground) nstate = FALL_L;
      end
      DIG_R: begin
        if (!lem.ground) nstate = FALL_R;
      end
      SPLAT: begin
`ifdef LEMMINGS_REVIVE_EN
        if (lem.revive) nstate = WALK_L;
`else
        nstate = SPLAT;
`endif
      end
      default: nstate = WALK_L;
    endcase
  end

  always_comb begin
    lem.walk_left  = 1'b0;
    lem.walk_right = 1'b0;
    lem.aaah       = 1'b0;
    lem.digging    = 1'b0;
    case (cstate)
      WALK_L:         lem.walk_left  = 1'b1;
      WALK_R:         lem.walk_right = 1'b1;
      FALL_L, FALL_R: lem.aaah       = 1'b1;
      DIG_L, DIG_R:   lem.digging    = 1'b1;
      default: ;
    endcase
  end

endmodule
